// File: rtl/adapter_axi_stream_2_ppfifo_wr.sv
// AXI Stream sink that fills ping-pong FIFO write buffers, releasing on full or tlast.
// Define ADAPTER_AXIS_2_PPFIFO_USER_EN to carry tuser[USER_COUNT-1:0] above the data word.
module adapter_axi_stream_2_ppfifo_wr #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_COUNT = 1
) (
  input  logic                           i_axi_clk,
  input  logic                           rst,
  input  logic [1:0]                     i_ppfifo_rdy,
  output logic [1:0]                     o_ppfifo_act,
  input  logic [23:0]                    i_ppfifo_size,
  output logic                           o_ppfifo_stb,
`ifdef ADAPTER_AXIS_2_PPFIFO_USER_EN
  output logic [DATA_WIDTH+USER_COUNT-1:0] o_ppfifo_data,
`else
  output logic [DATA_WIDTH-1:0]          o_ppfifo_data,
`endif
  input  logic [3:0]                     i_axi_user,
  input  logic                           i_axi_valid,
  output logic                           o_axi_ready,
  input  logic [DATA_WIDTH-1:0]          i_axi_data,
  input  logic                           i_axi_last,
  output logic                           o_frame_done
);

  localparam int unsigned CNT_W = 24;
`ifdef ADAPTER_AXIS_2_PPFIFO_USER_EN
  localparam int unsigned OUT_W = DATA_WIDTH + USER_COUNT;
`else
  localparam int unsigned OUT_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   count_n;
  logic [CNT_W-1:0]   count_inc;
  logic [1:0]         act_n;
  logic               stb_n;
  logic [OUT_W-1:0]   data_n;
  logic [OUT_W-1:0]   beat_word;
  logic               done_n;
  logic               accept;
  logic               unused_inputs;

`ifdef ADAPTER_AXIS_2_PPFIFO_USER_EN
  assign beat_word = {i_axi_user[USER_COUNT-1:0], i_axi_data};
`else
  assign beat_word = i_axi_data;
`endif
  assign unused_inputs = ^{i_axi_user, USER_COUNT[0]};

  // Ready is decoded from registers only so it never waits on tvalid.
  assign o_axi_ready = (state == WRITE) && (r_count < i_ppfifo_size);
  assign accept      = i_axi_valid && o_axi_ready;
  assign count_inc   = r_count + CNT_W'(1);

  always_comb begin
    state_n = state;
    count_n = r_count;
    act_n   = o_ppfifo_act;
    stb_n   = 1'b0;
    data_n  = o_ppfifo_data;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if ((o_ppfifo_act == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
          act_n   = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
          count_n = '0;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          stb_n   = 1'b1;
          data_n  = beat_word;
          count_n = count_inc;
          if (i_axi_last) begin
            done_n  = 1'b1;
            state_n = RELEASE;
          end else if (count_inc >= i_ppfifo_size) begin
            state_n = RELEASE;
          end
        end else if (r_count >= i_ppfifo_size) begin
          // Covers a zero-size grant: nothing can be written, hand it back.
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        act_n   = 2'b00;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state         <= IDLE;
      r_count       <= '0;
      o_ppfifo_act  <= 2'b00;
      o_ppfifo_stb  <= 1'b0;
      o_ppfifo_data <= '0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_n;
      r_count       <= count_n;
      o_ppfifo_act  <= act_n;
      o_ppfifo_stb  <= stb_n;
      o_ppfifo_data <= data_n;
      o_frame_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_adapter_axi_stream_2_ppfifo_wr.sv
// Bench for adapter_axi_stream_2_ppfifo_wr: directed and random streams against a frame/buffer model.
`timescale 1ns/1ps
module tb_adapter_axi_stream_2_ppfifo_wr;

  localparam int unsigned DW = 32;
  localparam int unsigned UC = 1;
`ifdef ADAPTER_AXIS_2_PPFIFO_USER_EN
  localparam int unsigned OW = DW + UC;
`else
  localparam int unsigned OW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rdy;
  logic [1:0]    act;
  logic [23:0]   size;
  logic          stb;
  logic [OW-1:0] data_o;
  logic [3:0]    user;
  logic          valid;
  logic          ready;
  logic [DW-1:0] din;
  logic          last;
  logic          fd;

  always #5 clk = ~clk;

  adapter_axi_stream_2_ppfifo_wr #(.DATA_WIDTH(DW), .USER_COUNT(UC)) dut (
    .i_axi_clk     (clk),
    .rst           (rst),
    .i_ppfifo_rdy  (rdy),
    .o_ppfifo_act  (act),
    .i_ppfifo_size (size),
    .o_ppfifo_stb  (stb),
    .o_ppfifo_data (data_o),
    .i_axi_user    (user),
    .i_axi_valid   (valid),
    .o_axi_ready   (ready),
    .i_axi_data    (din),
    .i_axi_last    (last),
    .o_frame_done  (fd)
  );

  int          total = 0;
  int          bad = 0;
  logic [1:0]  en;
  int          drain [2];
  logic [1:0]  prev_act;
  logic [31:0] exp_data [$];
  logic [31:0] got_data [$];
  logic [63:0] exp_per [$];
  logic [63:0] got_per [$];
  logic [1:0]  per_buf;
  int          per_cnt;
  bit          per_fd;
  int          stray;
  int          viol;
  int          m_cnt;
  logic [1:0]  m_buf;

  function automatic logic [63:0] enc(input logic [1:0] b, input int c, input bit f);
    return (64'(b) << 40) | (64'(c) << 1) | 64'(f);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe buffer periods, then play the PPFIFO write side.
  task automatic tick();
    @(negedge clk);
    if (act != 2'b00 && prev_act == 2'b00) begin
      per_buf = act;
      per_cnt = 0;
      per_fd  = 1'b0;
    end
    if (stb) begin
      got_data.push_back(data_o[DW-1:0]);
      if (act == 2'b00) stray++; else per_cnt++;
    end
    if (fd) begin
      if (act == 2'b00) stray++; else per_fd = 1'b1;
    end
    if (act == 2'b11) viol++;
    if (act == 2'b00 && prev_act != 2'b00) got_per.push_back(enc(per_buf, per_cnt, per_fd));
    prev_act = act;
    for (int i = 0; i < 2; i++) begin
      if (act[i]) begin
        rdy[i]   = 1'b0;
        drain[i] = 1;
      end else if (en[i] && !rdy[i]) begin
        if (drain[i] > 0) drain[i]--;
        else rdy[i] = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] en_new);
    rst = 1'b1; valid = 1'b0; last = 1'b0; en = en_new; rdy = 2'b00;
    drain[0] = 0; drain[1] = 0;
    tick(); tick();
    rst = 1'b0;
    exp_data.delete(); got_data.delete(); exp_per.delete(); got_per.delete();
    stray = 0; viol = 0; m_cnt = 0; m_buf = 2'b01;
  endtask

  // Reference: buffers fill until size or tlast; with both buffers in play they alternate.
  task automatic model_accept(input logic [31:0] d, input bit l);
    exp_data.push_back(d);
    m_cnt++;
    if (l || m_cnt == int'(size)) begin
      exp_per.push_back(enc(m_buf, m_cnt, l));
      m_cnt = 0;
      if (en == 2'b11) m_buf = ~m_buf;
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int t = 0; t < 50 && !ready; t++) tick();
    check({tag, "_ready"}, 64'(ready), 64'd1);
  endtask

  task automatic send_frame(input int len, input int vprob);
    for (int k = 0; k < len; k++) begin
      bit got_it = 1'b0;
      for (int t = 0; t < 300 && !got_it; t++) begin
        logic r0;
        tick();
        r0    = ready;
        valid = (int'($urandom_range(99)) < vprob);
        din   = $urandom;
        user  = 4'($urandom);
        last  = (k == len - 1);
        #1 check("ready_indep", 64'(ready), 64'(r0));
        if (valid && r0) begin
          model_accept(din, last);
          got_it = 1'b1;
        end
      end
      if (!got_it) begin
        check("beat_timeout", 64'd0, 64'd1);
        return;
      end
    end
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic flush(input string tag);
    int n;
    valid = 1'b0; last = 1'b0;
    for (int t = 0; t < 200 && (got_per.size() < exp_per.size() || got_data.size() < exp_data.size()); t++)
      tick();
    tick();
    check({tag, "_pending"}, 64'(m_cnt), 64'd0);
    check({tag, "_nbeats"}, 64'(got_data.size()), 64'(exp_data.size()));
    check({tag, "_nbufs"}, 64'(got_per.size()), 64'(exp_per.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_data%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    n = (got_per.size() < exp_per.size()) ? got_per.size() : exp_per.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_buf%0d", tag, i), got_per[i], exp_per[i]);
    check({tag, "_stray"}, 64'(stray), 64'd0);
    check({tag, "_onehot"}, 64'(viol), 64'd0);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; last = 1'b0; din = '0; user = '0;
    size = 24'd8; rdy = 2'b00; en = 2'b00; prev_act = 2'b00;
    per_buf = 2'b00; per_cnt = 0; per_fd = 1'b0;
    tick();
    check("reset_act", 64'(act), 64'd0);
    check("reset_stb", 64'(stb), 64'd0);
    check("reset_data", 64'(data_o), 64'd0);
    check("reset_done", 64'(fd), 64'd0);
    check("reset_ready", 64'(ready), 64'd0);

    // 1: single buffer, 8 beats ending in tlast, checking write latency per beat
    do_reset(2'b01);
    size = 24'd8;
    wait_ready("t1");
    check("t1_act", 64'(act), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t1_rdy", 64'(ready), 64'd1);
      valid = 1'b1; din = DW'(i); last = (i == 8);
      model_accept(din, last);
      tick();
      check("t1_stb", 64'(stb), 64'd1);
      check("t1_wdata", 64'(data_o[DW-1:0]), 64'(i));
    end
    check("t1_done", 64'(fd), 64'd1);
    check("t1_act_release", 64'(act), 64'd1);
    valid = 1'b0; last = 1'b0;
    tick();
    check("t1_act_drop", 64'(act), 64'd0);
    check("t1_done_pulse", 64'(fd), 64'd0);
    check("t1_stb_end", 64'(stb), 64'd0);
    flush("t1");

    // 2: frame of 10 across 4-word buffers
    do_reset(2'b11);
    size = 24'd4;
    send_frame(10, 100);
    flush("t2");

    // 3: early tlast, then next frame in a fresh buffer
    do_reset(2'b11);
    size = 24'd16;
    send_frame(3, 100);
    send_frame(5, 100);
    flush("t3");

    // 4: random frames, 50% tvalid
    do_reset(2'b11);
    size = 24'd32;
    for (int f = 0; f < 6; f++) send_frame(int'($urandom_range(1, 70)), 50);
    flush("t4");

    // 5: reset in the middle of a buffer
    do_reset(2'b01);
    size = 24'd8;
    wait_ready("t5");
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; din = $urandom; last = 1'b0;
      tick();
    end
    rst = 1'b1; valid = 1'b0;
    tick();
    check("t5_act", 64'(act), 64'd0);
    check("t5_stb", 64'(stb), 64'd0);
    check("t5_ready", 64'(ready), 64'd0);
    do_reset(2'b01);
    size = 24'd8;
    send_frame(8, 100);
    flush("t5");

    // no buffer ready: source held off, outputs quiet
    do_reset(2'b00);
    size = 24'd8;
    valid = 1'b1; din = $urandom;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nordy_quiet", 64'({act, stb, ready, fd}), 64'd0);
    end
    valid = 1'b0;

    // zero-size grant: released without writes
    do_reset(2'b00);
    size = 24'd0;
    rdy = 2'b01;
    for (int t = 0; t < 10 && act == 2'b00; t++) tick();
    check("sz0_act", 64'(act), 64'd1);
    check("sz0_ready", 64'(ready), 64'd0);
    tick(); tick();
    check("sz0_release", 64'(act), 64'd0);
    check("sz0_nowrite", 64'(got_data.size()), 64'd0);

`ifdef ADAPTER_AXIS_2_PPFIFO_USER_EN
    // tuser bit travels with its beat
    do_reset(2'b01);
    size = 24'd4;
    wait_ready("t6");
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; din = DW'(i + 10); user = (i == 0) ? 4'h1 : 4'h0; last = (i == 3);
      model_accept(din, last);
      tick();
      check("t6_user", 64'(data_o[DW]), 64'(i == 0));
    end
    flush("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
